// File: rtl/host_frame_fifo.sv
// -----------------------------------------------------------------------------
// host_frame_fifo
//   Single-clock host-side frame buffer. NCH eCPU producer channels write
//   DW-bit words into one DEPTH-word buffer. The eCPU commits the frame, which
//   raises srq. The host acknowledges and drains the frame with rd_en strobes.
//   The block also reports overflow, write collisions, dropped words and fill level.
//
// Ports
//   hb_clk, hb_rst_n  clock (rising edge) and async active-low reset
//   ch_wr, ch_din     per-channel write strobes; channel i data at [i*DW +: DW]
//   frm_commit        frame complete: FILL -> READY (ignored when empty)
//   frm_abort         discard the frame and go to IDLE; overrides all other inputs
//   srq, srq_ack      service request to host / host acceptance
//   rd_en             host pop strobe, honoured only while draining
//   rd_dout, rd_valid registered pop data, one cycle after an accepted rd_en
//   frm_len           word count of the committed frame
//   level             words currently held
//   busy              high in READY or DRAIN
//   ovfl, coll        sticky: full-buffer drop / multiple strobes in one cycle
//   drop_cnt          saturating count of dropped words
// -----------------------------------------------------------------------------
module host_frame_fifo #(
  parameter  int NCH   = 5,
  parameter  int DW    = 16,
  parameter  int DEPTH = 2048,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              hb_clk,
  input  logic              hb_rst_n,
  input  logic [NCH-1:0]    ch_wr,
  input  logic [NCH*DW-1:0] ch_din,
  input  logic              frm_commit,
  input  logic              frm_abort,
  output logic              srq,
  input  logic              srq_ack,
  input  logic              rd_en,
  output logic [DW-1:0]     rd_dout,
  output logic              rd_valid,
  output logic [AW:0]       frm_len,
  output logic [AW:0]       level,
  output logic              busy,
  output logic              ovfl,
  output logic              coll,
  output logic [15:0]       drop_cnt
);

  typedef enum logic [1:0] {IDLE, FILL, READY, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [AW:0]     frm_len_q, frm_len_d;
  logic            ovfl_q, ovfl_d;
  logic            coll_q, coll_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [DW-1:0]   rd_dout_q;
  logic            rd_valid_q;

  logic [DW-1:0]   mem [DEPTH];

  // Arbitration: count the asserted strobes and select the lowest-index winner.
  logic [3:0]      wr_cnt;
  logic [DW-1:0]   win_data;
  logic            found;

  // NOTE: always_comb gives every variable a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    wr_cnt   = '0;
    win_data = '0;
    found    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_wr[i]) begin
        wr_cnt = wr_cnt + 4'd1;
        if (!found) begin
          win_data = ch_din[i*DW +: DW];
          found    = 1'b1;
        end
      end
    end
  end

  logic        can_write, full, wr_acc, rd_pop, drain_done, clr;
  logic [AW:0] level_inc;
  logic [3:0]  drops;
  logic [16:0] drop_sum;

  assign can_write  = (state_q == IDLE) || (state_q == FILL);
  assign full       = (level_q == (AW+1)'(DEPTH));
  assign wr_acc     = found && can_write && !full && !frm_abort;
  assign rd_pop     = (state_q == DRAIN) && rd_en && (level_q != '0) && !frm_abort;
  assign drain_done = rd_pop && (level_q == (AW+1)'(1));
  assign clr        = frm_abort || drain_done;
  // Level with a same-cycle write already included, so that a commit counts the word.
  assign level_inc  = level_q + (AW+1)'(wr_acc);
  // Every asserted strobe that is not stored is dropped: collision losers,
  // a winner that hits a full buffer, and all writes outside IDLE/FILL.
  assign drops      = frm_abort ? 4'd0 : wr_cnt - 4'(wr_acc);
  assign drop_sum   = {1'b0, drop_cnt_q} + 17'(drops);

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples values from before the clock edge.
  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (frm_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        // A commit that arrives with the very first word still closes the frame.
        IDLE:  if (wr_acc) state_d = frm_commit ? READY : FILL;
        FILL:  if (frm_commit && (level_inc != '0)) state_d = READY;
        READY: if (srq_ack) state_d = DRAIN;
        DRAIN: if (drain_done) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    srq  = (state_q == READY);
    busy = (state_q == READY) || (state_q == DRAIN);
  end

  // ---------------- Datapath next state ----------------
  always_comb begin
    wr_ptr_d   = clr ? '0 : wr_ptr_q + AW'(wr_acc);
    rd_ptr_d   = clr ? '0 : rd_ptr_q + AW'(rd_pop);
    level_d    = clr ? '0 : level_inc - (AW+1)'(rd_pop);
    frm_len_d  = frm_len_q;
    if (clr)
      frm_len_d = '0;
    else if ((state_q != READY) && (state_d == READY))
      frm_len_d = level_inc;
    // ovfl marks a drop caused by a full buffer only. A drop in READY/DRAIN is a
    // state drop, even at full level.
    ovfl_d     = ovfl_q | (!frm_abort && found && can_write && full);
    coll_d     = coll_q | (!frm_abort && (wr_cnt > 4'd1));
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      frm_len_q  <= '0;
      ovfl_q     <= 1'b0;
      coll_q     <= 1'b0;
      drop_cnt_q <= '0;
      rd_dout_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      frm_len_q  <= frm_len_d;
      ovfl_q     <= ovfl_d;
      coll_q     <= coll_d;
      drop_cnt_q <= drop_cnt_d;
      rd_valid_q <= rd_pop;
      if (rd_pop) rd_dout_q <= mem[rd_ptr_q];
    end
  end

  // NOTE: the storage array has no reset, so it can map onto block RAM.
  // Words are only read after they have been written.
  always_ff @(posedge hb_clk) begin
    if (wr_acc) mem[wr_ptr_q] <= win_data;
  end

  assign rd_dout  = rd_dout_q;
  assign rd_valid = rd_valid_q;
  assign frm_len  = frm_len_q;
  assign level    = level_q;
  assign ovfl     = ovfl_q;
  assign coll     = coll_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_host_frame_fifo.sv
// -----------------------------------------------------------------------------
// tb_host_frame_fifo
//   Directed bench for host_frame_fifo with a 16-word buffer. Each task drives
//   one scenario and compares the DUT outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_host_frame_fifo;

  localparam int NCH   = 5;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic              hb_clk = 1'b0;
  logic              hb_rst_n;
  logic [NCH-1:0]    ch_wr;
  logic [NCH*DW-1:0] ch_din;
  logic              frm_commit, frm_abort, srq_ack, rd_en;
  logic              srq, rd_valid, busy, ovfl, coll;
  logic [DW-1:0]     rd_dout;
  logic [AW:0]       frm_len, level;
  logic [15:0]       drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  host_frame_fifo #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .hb_clk(hb_clk), .hb_rst_n(hb_rst_n), .ch_wr(ch_wr), .ch_din(ch_din),
    .frm_commit(frm_commit), .frm_abort(frm_abort), .srq(srq), .srq_ack(srq_ack),
    .rd_en(rd_en), .rd_dout(rd_dout), .rd_valid(rd_valid), .frm_len(frm_len),
    .level(level), .busy(busy), .ovfl(ovfl), .coll(coll), .drop_cnt(drop_cnt)
  );

  always #5 hb_clk = ~hb_clk;

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge hb_clk);
    #1;
  endtask

  task automatic put_word(input int ch, input logic [DW-1:0] d);
    ch_wr  = '0;
    ch_din = '0;
    ch_wr[ch] = 1'b1;
    ch_din[ch*DW +: DW] = d;
    tick();
    ch_wr  = '0;
    ch_din = '0;
  endtask

  task automatic commit_and_ack();
    frm_commit = 1'b1;
    tick();
    frm_commit = 1'b0;
    srq_ack = 1'b1;
    tick();
    srq_ack = 1'b0;
  endtask

  task automatic test_reset();
    hb_rst_n = 1'b0;
    #12;
    n_checks++; if (srq !== 1'b0)      begin n_fail++; $display("FAIL reset_srq got %0h want 0", srq); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %0h want 0", busy); end
    n_checks++; if (level !== '0)      begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %0h want 0", rd_valid); end
    n_checks++; if (rd_dout !== '0)    begin n_fail++; $display("FAIL reset_rd_dout got %0h want 0", rd_dout); end
    n_checks++; if ({ovfl, coll} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {ovfl, coll}); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
    n_checks++; if (frm_len !== '0)    begin n_fail++; $display("FAIL reset_frm_len got %0d want 0", frm_len); end
    #5 hb_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 16'hA001; exp_d[1] = 16'hA002; exp_d[2] = 16'hA003;
    for (int i = 0; i < 3; i++) put_word(2, exp_d[i]);
    n_checks++; if (level !== 5'd3) begin n_fail++; $display("FAIL basic_level_fill got %0d want 3", level); end
    n_checks++; if (srq !== 1'b0)   begin n_fail++; $display("FAIL basic_srq_fill got %0h want 0", srq); end
    frm_commit = 1'b1;
    tick();
    frm_commit = 1'b0;
    n_checks++; if (srq !== 1'b1)     begin n_fail++; $display("FAIL basic_srq got %0h want 1", srq); end
    n_checks++; if (busy !== 1'b1)    begin n_fail++; $display("FAIL basic_busy got %0h want 1", busy); end
    n_checks++; if (frm_len !== 5'd3) begin n_fail++; $display("FAIL basic_frm_len got %0d want 3", frm_len); end
    // A pop strobe before the acknowledge is ignored.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_rd got %0h want 0", rd_valid); end
    n_checks++; if (level !== 5'd3)    begin n_fail++; $display("FAIL basic_early_level got %0d want 3", level); end
    srq_ack = 1'b1;
    tick();
    srq_ack = 1'b0;
    n_checks++; if (srq !== 1'b0)  begin n_fail++; $display("FAIL basic_srq_after_ack got %0h want 0", srq); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_drain got %0h want 1", busy); end
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      tick();
      n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_rd_valid[%0d] got %0h want 1", i, rd_valid); end
      n_checks++; if (rd_dout !== exp_d[i]) begin n_fail++; $display("FAIL basic_rd_dout[%0d] got %0h want %0h", i, rd_dout, exp_d[i]); end
    end
    rd_en = 1'b0;
    n_checks++; if (level !== '0)  begin n_fail++; $display("FAIL basic_level_end got %0d want 0", level); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle got %0h want 0", busy); end
    tick();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_rd_valid_off got %0h want 0", rd_valid); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) put_word(0, 16'hC000 + 16'(i));
    n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL full_level got %0d want 16", level); end
    n_checks++; if (ovfl !== 1'b0)   begin n_fail++; $display("FAIL full_ovfl_pre got %0h want 0", ovfl); end
    put_word(3, 16'hDEAD);
    put_word(3, 16'hBEEF);
    n_checks++; if (ovfl !== 1'b1)       begin n_fail++; $display("FAIL full_ovfl got %0h want 1", ovfl); end
    n_checks++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL full_drop_cnt got %0d want 2", drop_cnt); end
    n_checks++; if (level !== 5'd16)     begin n_fail++; $display("FAIL full_level_hold got %0d want 16", level); end
    commit_and_ack();
    n_checks++; if (frm_len !== 5'd16) begin n_fail++; $display("FAIL full_frm_len got %0d want 16", frm_len); end
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1;
      tick();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_dout !== 16'hC000 + 16'(i)) begin
        n_fail++; $display("FAIL full_drain[%0d] got v=%0h d=%0h want v=1 d=%0h", i, rd_valid, rd_dout, 16'hC000 + 16'(i));
      end
    end
    rd_en = 1'b0;
    n_checks++; if (busy !== 1'b0 || level !== '0) begin n_fail++; $display("FAIL full_end got busy=%0h level=%0d want 0/0", busy, level); end
    tick();
  endtask

  task automatic test_collision();
    ch_wr = 5'b00110;
    ch_din = '0;
    ch_din[1*DW +: DW] = 16'h1111;
    ch_din[2*DW +: DW] = 16'h2222;
    tick();
    ch_wr = '0;
    ch_din = '0;
    n_checks++; if (coll !== 1'b1)       begin n_fail++; $display("FAIL coll_flag got %0h want 1", coll); end
    n_checks++; if (drop_cnt !== 16'd3) begin n_fail++; $display("FAIL coll_drop_cnt got %0d want 3", drop_cnt); end
    n_checks++; if (level !== 5'd1)      begin n_fail++; $display("FAIL coll_level got %0d want 1", level); end
    commit_and_ack();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++; if (rd_dout !== 16'h1111 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL coll_word got v=%0h d=%0h want v=1 d=1111", rd_valid, rd_dout); end
    tick();
  endtask

  task automatic test_commit_and_abort();
    for (int i = 0; i < 4; i++) put_word(4, 16'hE000 + 16'(i));
    // The fifth word and the commit arrive in the same cycle.
    ch_wr = 5'b10000;
    ch_din = '0;
    ch_din[4*DW +: DW] = 16'hE004;
    frm_commit = 1'b1;
    tick();
    ch_wr = '0;
    ch_din = '0;
    frm_commit = 1'b0;
    n_checks++; if (srq !== 1'b1)     begin n_fail++; $display("FAIL same_cycle_srq got %0h want 1", srq); end
    n_checks++; if (frm_len !== 5'd5) begin n_fail++; $display("FAIL same_cycle_frm_len got %0d want 5", frm_len); end
    // A write in READY is dropped and counted.
    put_word(0, 16'h0BAD);
    n_checks++; if (drop_cnt !== 16'd4) begin n_fail++; $display("FAIL ready_drop_cnt got %0d want 4", drop_cnt); end
    n_checks++; if (level !== 5'd5)      begin n_fail++; $display("FAIL ready_level got %0d want 5", level); end
    srq_ack = 1'b1;
    tick();
    srq_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_en = 1'b1;
      tick();
      n_checks++; if (rd_dout !== 16'hE000 + 16'(i)) begin n_fail++; $display("FAIL abort_pop[%0d] got %0h want %0h", i, rd_dout, 16'hE000 + 16'(i)); end
    end
    // The abort arrives together with a pop strobe and overrides it.
    frm_abort = 1'b1;
    tick();
    frm_abort = 1'b0;
    rd_en = 1'b0;
    n_checks++; if (busy !== 1'b0 || srq !== 1'b0) begin n_fail++; $display("FAIL abort_state got busy=%0h srq=%0h want 0/0", busy, srq); end
    n_checks++; if (level !== '0)      begin n_fail++; $display("FAIL abort_level got %0d want 0", level); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rd_valid got %0h want 0", rd_valid); end
    n_checks++; if (ovfl !== 1'b1 || drop_cnt !== 16'd4) begin n_fail++; $display("FAIL abort_sticky got ovfl=%0h drop=%0d want 1/4", ovfl, drop_cnt); end
    // A commit in IDLE with an empty buffer does nothing.
    frm_commit = 1'b1;
    tick();
    frm_commit = 1'b0;
    n_checks++; if (srq !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_commit got srq=%0h busy=%0h want 0/0", srq, busy); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) put_word(1, 16'h5500 + 16'(i));
    #2 hb_rst_n = 1'b0;
    #1;
    n_checks++; if (level !== '0 || srq !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL async_state got level=%0d srq=%0h busy=%0h want 0", level, srq, busy); end
    n_checks++; if (ovfl !== 1'b0 || coll !== 1'b0 || drop_cnt !== '0) begin n_fail++; $display("FAIL async_flags got ovfl=%0h coll=%0h drop=%0d want 0", ovfl, coll, drop_cnt); end
    n_checks++; if (rd_dout !== '0 || rd_valid !== 1'b0 || frm_len !== '0) begin n_fail++; $display("FAIL async_rd got d=%0h v=%0h len=%0d want 0", rd_dout, rd_valid, frm_len); end
    #2 hb_rst_n = 1'b1;
    put_word(3, 16'hD001);
    put_word(3, 16'hD002);
    commit_and_ack();
    n_checks++; if (frm_len !== 5'd2) begin n_fail++; $display("FAIL async_frm_len got %0d want 2", frm_len); end
    for (int i = 0; i < 2; i++) begin
      rd_en = 1'b1;
      tick();
      n_checks++; if (rd_dout !== 16'hD001 + 16'(i)) begin n_fail++; $display("FAIL async_drain[%0d] got %0h want %0h", i, rd_dout, 16'hD001 + 16'(i)); end
    end
    rd_en = 1'b0;
    n_checks++; if (busy !== 1'b0 || level !== '0) begin n_fail++; $display("FAIL async_end got busy=%0h level=%0d want 0/0", busy, level); end
  endtask

  initial begin
    ch_wr = '0; ch_din = '0;
    frm_commit = 1'b0; frm_abort = 1'b0; srq_ack = 1'b0; rd_en = 1'b0;
    test_reset();
    test_basic_frame();
    test_full();
    test_collision();
    test_commit_and_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
